data_mem_ctrl: RTL and testbench

//  Multi-cycle data-memory stage directly upstream of the register file. Accepts one load or

---
 rtl/cpu_pkg.sv | 12 +
 rtl/data_mem_array.sv | 19 +
 rtl/data_mem_ctrl.sv | 98 +++++++++
 tb/tb_data_mem_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the data-memory stage.
package cpu_pkg;
  localparam int A_DEF   = 4;
  localparam int W_DEF   = 8;
  localparam int DA_DEF  = 8;
  localparam int LAT_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;
endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage: synchronous write, combinational read, no reset on contents.
module data_mem_array #(
  parameter int DA = 8,
  parameter int W  = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [DA-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [2**DA];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle load/store stage: one request at a time, fixed latency LAT, one-cycle
// write-back strobe for loads, stall while busy.
module data_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int A   = A_DEF,
  parameter int W   = W_DEF,
  parameter int DA  = DA_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [DA-1:0] req_addr,
  input  logic [W-1:0]  req_wdata,
  input  logic [A-1:0]  req_rd,
  output logic          stall,
  output logic          wb_en,
  output logic          wb_from_mem,
  output logic [A-1:0]  wb_addr,
  output logic [W-1:0]  wb_data
);
  mem_state_e    state_q;
  logic [3:0]    cnt_q;
  logic          write_q;
  logic [DA-1:0] addr_q;
  logic [W-1:0]  wdata_q;
  logic [A-1:0]  rd_q;
  logic          wb_en_q;
  logic [A-1:0]  wb_addr_q;
  logic [W-1:0]  wb_data_q;

  logic          done_d;
  logic          mem_we_d;
  logic [W-1:0]  rdata_d;

  // Completing edge: last BUSY cycle. An aborting reset never reaches it, so no commit.
  assign done_d   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we_d = done_d && write_q;

  data_mem_array #(.DA(DA), .W(W)) u_array (
    .clk_i   (clk),
    .we_i    (mem_we_d),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata_d)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            cnt_q   <= 4'(LAT - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
            if (!write_q) begin
              wb_en_q   <= 1'b1;
              wb_addr_q <= rd_q;
              wb_data_q <= rdata_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign stall       = req_valid & ~req_ready;
  assign wb_en       = wb_en_q;
  assign wb_from_mem = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: LAT=2 main instance plus a LAT=1 instance.
module tb_data_mem_ctrl;
  logic       clk = 1'b0;
  logic       Reset;

  logic       req_valid, req_write;
  logic [7:0] req_addr, req_wdata;
  logic [3:0] req_rd;
  logic       req_ready, stall, wb_en, wb_from_mem;
  logic [3:0] wb_addr;
  logic [7:0] wb_data;

  logic       b_valid, b_write;
  logic [7:0] b_addr, b_wdata;
  logic [3:0] b_rd;
  logic       b_ready, b_stall, b_wb_en, b_wb_from_mem;
  logic [3:0] b_wb_addr;
  logic [7:0] b_wb_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.A(4), .W(8), .DA(8), .LAT(2)) dut (
    .clk(clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall), .wb_en(wb_en), .wb_from_mem(wb_from_mem),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );

  data_mem_ctrl #(.A(4), .W(8), .DA(8), .LAT(1)) dut1 (
    .clk(clk), .Reset(Reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_rd(b_rd),
    .stall(b_stall), .wb_en(b_wb_en), .wb_from_mem(b_wb_from_mem),
    .wb_addr(b_wb_addr), .wb_data(b_wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full LAT=2 request on the main instance, ending at the write-back cycle.
  task automatic do_req(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [3:0] rd);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_rd = rd;
    step();
    req_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    Reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    b_valid = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_rd = 0;
    @(negedge clk);
    chk("rst_wb_en", 32'(wb_en), 32'h0);
    chk("rst_wb_data", 32'(wb_data), 32'h0);
    @(negedge clk);
    Reset = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_stall", 32'(stall), 32'h0);
    @(negedge clk);

    // Store then load
    do_req(1'b1, 8'h10, 8'hA5, 4'd0);
    chk("st_ready_back", 32'(req_ready), 32'h1);
    chk("st_no_wb", 32'(wb_en), 32'h0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_rd = 4'd3;
    step();
    req_valid = 1'b0;
    chk("ld_busy_ready", 32'(req_ready), 32'h0);
    step();
    chk("ld_no_early_wb", 32'(wb_en), 32'h0);
    step();
    chk("ld_wb_en", 32'(wb_en), 32'h1);
    chk("ld_wb_from_mem", 32'(wb_from_mem), 32'h1);
    chk("ld_wb_addr", 32'(wb_addr), 32'h3);
    chk("ld_wb_data", 32'(wb_data), 32'hA5);
    step();
    chk("ld_wb_one_cycle", 32'(wb_en), 32'h0);
    chk("ld_wb_data_hold", 32'(wb_data), 32'hA5);

    // Asynchronous mid-cycle reset clears write-back registers immediately
    #2 Reset = 1'b1;
    #1;
    chk("async_wb_data", 32'(wb_data), 32'h0);
    chk("async_wb_en", 32'(wb_en), 32'h0);
    @(negedge clk);
    Reset = 1'b0;
    #1;
    chk("async_ready", 32'(req_ready), 32'h1);
    @(negedge clk);

    // LAT=1 back-to-back on the second instance
    b_valid = 1'b1; b_write = 1'b1; b_addr = 8'h00; b_wdata = 8'h7F; b_rd = 4'd0;
    step();
    b_write = 1'b0; b_rd = 4'd15;
    chk("l1_busy", 32'(b_ready), 32'h0);
    chk("l1_stall", 32'(b_stall), 32'h1);
    step();
    chk("l1_ready_2cyc", 32'(b_ready), 32'h1);
    step();
    b_valid = 1'b0;
    step();
    chk("l1_wb_en", 32'(b_wb_en), 32'h1);
    chk("l1_wb_data", 32'(b_wb_data), 32'h7F);
    chk("l1_wb_addr", 32'(b_wb_addr), 32'hF);
    step();
    chk("l1_wb_drop", 32'(b_wb_en), 32'h0);

    // Continuous loads: ready 1,0,0 repeating, one strobe per 3 cycles
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_rd = 4'd5;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("cont_ready_%0d", k), 32'(req_ready), 32'((k % 3) == 0));
      chk($sformatf("cont_stall_%0d", k), 32'(stall), 32'((k % 3) != 0));
      chk($sformatf("cont_wb_en_%0d", k), 32'(wb_en), 32'((k > 0) && ((k % 3) == 0)));
      step();
    end
    req_valid = 1'b0;
    chk("cont_last_wb", 32'(wb_en), 32'h1);
    chk("cont_last_addr", 32'(wb_addr), 32'h5);
    step();

    // Reset during a store aborts it
    do_req(1'b1, 8'h20, 8'h33, 4'd0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h55;
    step();
    req_valid = 1'b0;
    step();
    Reset = 1'b1;
    #1;
    chk("abort_no_wb", 32'(wb_en), 32'h0);
    step();
    Reset = 1'b0;
    chk("abort_no_wb2", 32'(wb_en), 32'h0);
    do_req(1'b0, 8'h20, 8'h00, 4'd7);
    chk("abort_not_committed", 32'(wb_data), 32'h33);
    do_req(1'b1, 8'h20, 8'h11, 4'd0);
    do_req(1'b0, 8'h20, 8'h00, 4'd7);
    chk("after_abort_wb_en", 32'(wb_en), 32'h1);
    chk("after_abort_data", 32'(wb_data), 32'h11);
    chk("after_abort_addr", 32'(wb_addr), 32'h7);

    // Input changes while busy are ignored
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_rd = 4'd9;
    step();
    req_valid = 1'b0; req_addr = 8'h20; req_rd = 4'd2;
    step();
    req_addr = 8'h00; req_rd = 4'd1;
    step();
    chk("busy_chg_wb_en", 32'(wb_en), 32'h1);
    chk("busy_chg_addr", 32'(wb_addr), 32'h9);
    chk("busy_chg_data", 32'(wb_data), 32'hA5);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
